// File: rtl/score_scan_ctrl.sv
// Two-player BCD score keeper with win detection and a 4-digit scan select
// for a multiplexed 7-segment display.
module score_scan_ctrl #(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [1:0] Sel,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [0:0]  ST_PLAY  = 1'b0;
  localparam logic [0:0]  ST_OVER  = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);
  localparam logic [6:0]  WIN      = 7'(WIN_SCORE);
  localparam bit          WIN_EN   = (WIN_SCORE != 0);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  sync1_q, sync2_q, prev_q;
  logic [7:0]  p1_q, p1_d, p2_q, p2_d;
  logic [0:0]  state_q, state_d;
  logic [1:0]  winner_q, winner_d;
  logic        tick, inc1, inc2, hit1, hit2;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  assign tick = (cnt_q == CNT_LAST);
  assign inc1 = sync2_q[0] & ~prev_q[0];
  assign inc2 = sync2_q[1] & ~prev_q[1];
  assign hit1 = WIN_EN && (bcd_val(p1_q) == WIN);
  assign hit2 = WIN_EN && (bcd_val(p2_q) == WIN);

  always_comb begin
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    sel_d    = tick ? sel_q + 2'd1 : sel_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    state_d  = state_q;
    winner_d = winner_q;
    if (clr) begin
      // any increment landing in this cycle is intentionally discarded
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      state_d  = ST_PLAY;
      winner_d = 2'b00;
    end else if (state_q == ST_PLAY) begin
      if (hit1 || hit2) begin
        state_d  = ST_OVER;
        winner_d = {hit2, hit1};
      end else begin
        if (inc1) p1_d = bcd_inc(p1_q);
        if (inc2) p2_d = bcd_inc(p2_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 16'd0;
      sel_q    <= 2'd0;
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      prev_q   <= 2'b00;
      p1_q     <= 8'h00;
      p2_q     <= 8'h00;
      state_q  <= ST_PLAY;
      winner_q <= 2'b00;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sync1_q  <= {p2_point, p1_point};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  assign A         = p1_q[7:4];
  assign B         = p1_q[3:0];
  assign C         = p2_q[7:4];
  assign D         = p2_q[3:0];
  assign Sel       = sel_q;
  assign game_over = (state_q == ST_OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Bench for score_scan_ctrl: one instance with WIN_SCORE=10 and one with
// WIN_SCORE=0, both checked every cycle against an integer score model.
module tb_score_scan_ctrl;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic p1_point = 1'b0;
  logic p2_point = 1'b0;

  logic [3:0] a0, b0, c0, d0, a1, b1, c1, d1;
  logic [1:0] sel0, sel1, win0, win1;
  logic       go0, go1;
  logic [20:0] obs [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_scan_ctrl #(.PRESCALE(P), .WIN_SCORE(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .p1_point(p1_point), .p2_point(p2_point),
    .A(a0), .B(b0), .C(c0), .D(d0), .Sel(sel0), .game_over(go0), .winner(win0));

  score_scan_ctrl #(.PRESCALE(P), .WIN_SCORE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .p1_point(p1_point), .p2_point(p2_point),
    .A(a1), .B(b1), .C(c1), .D(d1), .Sel(sel1), .game_over(go1), .winner(win1));

  assign obs[0] = {a0, b0, c0, d0, sel0, go0, win0};
  assign obs[1] = {a1, b1, c1, d1, sel1, go1, win1};

  // Reference model: integer scores, edge count for the scan position, and
  // a three-deep history of sampled inputs giving the synchroniser latency.
  int       win_target [2] = '{10, 0};
  int       s1 [2], s2 [2];
  bit       ov [2];
  bit [1:0] wn [2];
  bit [2:0] h1, h2;
  int       ecnt;

  always @(posedge clk or negedge rst_n) begin
    bit i1, i2;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin s1[i] = 0; s2[i] = 0; ov[i] = 0; wn[i] = 0; end
      h1 = 0; h2 = 0; ecnt = 0;
    end else begin
      i1 = h1[1] & ~h1[2];
      i2 = h2[1] & ~h2[2];
      h1 = {h1[1:0], p1_point};
      h2 = {h2[1:0], p2_point};
      ecnt++;
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          s1[i] = 0; s2[i] = 0; ov[i] = 0; wn[i] = 0;
        end else if (!ov[i]) begin
          if (win_target[i] != 0 && (s1[i] == win_target[i] || s2[i] == win_target[i])) begin
            ov[i] = 1;
            wn[i] = {s2[i] == win_target[i], s1[i] == win_target[i]};
          end else begin
            if (i1 && s1[i] < 99) s1[i]++;
            if (i2 && s2[i] < 99) s2[i]++;
          end
        end
      end
    end
  end

  function automatic logic [20:0] expv(int i);
    logic [3:0] t1, u1, t2, u2;
    logic [1:0] sl;
    t1 = 4'(s1[i] / 10); u1 = 4'(s1[i] % 10);
    t2 = 4'(s2[i] / 10); u2 = 4'(s2[i] % 10);
    sl = 2'((ecnt / P) % 4);
    return {t1, u1, t2, u2, sl, ov[i], wn[i]};
  endfunction

  task automatic test_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs[i] !== 21'd0) begin
        n_fail++; $display("FAIL reset_hold dut%0d: got %h want 0", i, obs[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs[i] !== expv(i)) begin
        n_fail++; $display("FAIL reset_release dut%0d: got %h want %h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_scan();
    logic [1:0] prev_sel;
    int changes;
    prev_sel = sel0; changes = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (sel0 !== prev_sel) changes++;
      prev_sel = sel0;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL scan dut%0d: got %h want %h", i, obs[i], expv(i));
        end
      end
    end
    n_checks++;
    if (changes != 32 / P) begin
      n_fail++; $display("FAIL scan_steps: got %0d sel changes want %0d", changes, 32 / P);
    end
  endtask

  task automatic test_hold();
    p1_point = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) p1_point = 1'b0;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL hold dut%0d cyc%0d: got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    n_checks++;
    if ({a0, b0} !== 8'h01) begin
      n_fail++; $display("FAIL hold_once: got %h want 01", {a0, b0});
    end
  endtask

  task automatic test_p1_win();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    repeat (19) begin
      p1_point = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0) p1_point = 1'b0;
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs[i] !== expv(i)) begin
            n_fail++; $display("FAIL p1_win dut%0d: got %h want %h", i, obs[i], expv(i));
          end
        end
      end
    end
    n_checks++;
    if ({a0, b0, go0, win0} !== {8'h10, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL p1_win_final: got %h want %h", {a0, b0, go0, win0}, {8'h10, 1'b1, 2'b01});
    end
    n_checks++;
    if ({a1, b1, go1} !== {8'h19, 1'b0}) begin
      n_fail++; $display("FAIL p1_nowin_final: got %h want %h", {a1, b1, go1}, {8'h19, 1'b0});
    end
  endtask

  task automatic test_tie();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    repeat (10) begin
      p1_point = 1'b1; p2_point = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0) begin p1_point = 1'b0; p2_point = 1'b0; end
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs[i] !== expv(i)) begin
            n_fail++; $display("FAIL tie dut%0d: got %h want %h", i, obs[i], expv(i));
          end
        end
      end
    end
    n_checks++;
    if ({a0, b0, c0, d0, go0, win0} !== {16'h1010, 1'b1, 2'b11}) begin
      n_fail++; $display("FAIL tie_final: got %h want %h", {a0, b0, c0, d0, go0, win0}, {16'h1010, 1'b1, 2'b11});
    end
  endtask

  task automatic test_saturate();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    repeat (100) begin
      p2_point = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c == 0) p2_point = 1'b0;
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (obs[i] !== expv(i)) begin
            n_fail++; $display("FAIL saturate dut%0d: got %h want %h", i, obs[i], expv(i));
          end
        end
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({c1, d1, go1, win1} !== {8'h99, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL saturate_final: got %h want %h", {c1, d1, go1, win1}, {8'h99, 3'b000});
    end
    n_checks++;
    if ({c0, d0, go0, win0} !== {8'h10, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL p2_win_final: got %h want %h", {c0, d0, go0, win0}, {8'h10, 1'b1, 2'b10});
    end
  endtask

  task automatic test_clr_over();
    logic [1:0] sel_before;
    p1_point = 1'b1;
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    sel_before = sel0;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if ({a0, b0, c0, d0, go0, win0, a1, b1, c1, d1, go1} !== 38'd0) begin
      n_fail++; $display("FAIL clr_over: got %h want 0", {a0, b0, c0, d0, go0, win0, a1, b1, c1, d1, go1});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL clr_hold dut%0d: got %h want %h", i, obs[i], expv(i));
        end
      end
    end
    n_checks++;
    if ({a0, b0} !== 8'h00) begin
      n_fail++; $display("FAIL clr_no_rescore: got %h want 00", {a0, b0});
    end
    if (sel_before === 2'bxx) n_fail++;
    p1_point = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL random dut%0d cyc%0d: got %h want %h", i, c, obs[i], expv(i));
        end
      end
      p1_point = ($urandom % 3) == 0;
      p2_point = ($urandom % 3) == 0;
      clr      = ($urandom % 60) == 0;
    end
    p1_point = 1'b0; p2_point = 1'b0; clr = 1'b0;
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs[i] !== 21'd0) begin
        n_fail++; $display("FAIL async_reset dut%0d: got %h want 0", i, obs[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL post_reset dut%0d: got %h want %h", i, obs[i], expv(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hold();
    test_p1_win();
    test_tie();
    test_saturate();
    test_clr_over();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
